// File: rtl/vote_collector.sv
// Vote collector: synchronises and debounces raw voter buttons, then latches one vote per voter
// inside a timed session. Optional build macro VOTE_RETRACT_EN turns presses into vote toggles.
module vote_collector #(
    parameter int unsigned N_VOTERS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned WINDOW_CYCLES   = 1000
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [N_VOTERS-1:0]                  btn,
    output logic [N_VOTERS-1:0]                  vote,
    output logic [N_VOTERS-1:0]                  voted,
    output logic                                 session_open,
    output logic                                 done,
    output logic [$clog2(WINDOW_CYCLES+1)-1:0]   time_left
);

    localparam int unsigned TW = $clog2(WINDOW_CYCLES + 1);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OPEN   = 2'd1,
        S_CLOSED = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [N_VOTERS-1:0]   sync1_q, sync1_d;
    logic [N_VOTERS-1:0]   sync2_q, sync2_d;
    logic [N_VOTERS-1:0]   level_q, level_d;
    logic [N_VOTERS-1:0]   level_prev_q, level_prev_d;
    logic [CW-1:0]         cnt_q [N_VOTERS];
    logic [CW-1:0]         cnt_d [N_VOTERS];
    logic [N_VOTERS-1:0]   vote_q, vote_d;
    logic [N_VOTERS-1:0]   voted_q, voted_d;
    logic                  open_q, open_d;
    logic                  done_q, done_d;
    logic [TW-1:0]         time_left_q, time_left_d;
    logic [N_VOTERS-1:0]   press_c;
    logic                  close_c;

    // Input path: two-flop synchroniser, then a per-bit stability counter.
    // The level flips after the synced value has disagreed with it on DEBOUNCE_CYCLES+1 edges.
    always_comb begin
        sync1_d      = btn;
        sync2_d      = sync1_q;
        level_d      = level_q;
        level_prev_d = level_q;
        for (int unsigned k = 0; k < N_VOTERS; k++) begin
            cnt_d[k] = cnt_q[k];
            if (sync2_q[k] == level_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CW'(DEBOUNCE_CYCLES)) begin
                level_d[k] = sync2_q[k];
                cnt_d[k]   = '0;
            end else begin
                cnt_d[k] = cnt_q[k] + CW'(1);
            end
        end
        press_c = level_q & ~level_prev_q;
    end

    // Session control and vote latching.
    always_comb begin
        state_d     = state_q;
        vote_d      = vote_q;
        voted_d     = voted_q;
        time_left_d = time_left_q;
        done_d      = 1'b0;
        close_c     = 1'b0;
        case (state_q)
            S_IDLE, S_CLOSED: begin
                if (start) begin
                    state_d     = S_OPEN;
                    vote_d      = '0;
                    voted_d     = '0;
                    time_left_d = TW'(WINDOW_CYCLES);
                end
            end
            S_OPEN: begin
                time_left_d = time_left_q - TW'(1);
`ifdef VOTE_RETRACT_EN
                vote_d  = vote_q ^ press_c;
                voted_d = voted_q | press_c;
                close_c = (time_left_q == TW'(1));
`else
                vote_d  = vote_q | (press_c & ~voted_q);
                voted_d = voted_q | press_c;
                close_c = (time_left_q == TW'(1)) || (&voted_d);
`endif
                if (close_c) begin
                    state_d = S_CLOSED;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        open_d = (state_d == S_OPEN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            for (int unsigned k = 0; k < N_VOTERS; k++) begin
                cnt_q[k] <= '0;
            end
            vote_q       <= '0;
            voted_q      <= '0;
            open_q       <= 1'b0;
            done_q       <= 1'b0;
            time_left_q  <= '0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            for (int unsigned k = 0; k < N_VOTERS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            vote_q       <= vote_d;
            voted_q      <= voted_d;
            open_q       <= open_d;
            done_q       <= done_d;
            time_left_q  <= time_left_d;
        end
    end

    assign vote         = vote_q;
    assign voted        = voted_q;
    assign session_open = open_q;
    assign done         = done_q;
    assign time_left    = time_left_q;

endmodule

// File: tb/tb_vote_collector.sv
// Self-checking bench for vote_collector: directed scenarios plus random button traffic,
// compared every cycle against a window-based behavioural model.
module tb_vote_collector;

    localparam int D  = 4;
    localparam int W  = 80;
    localparam int TW = $clog2(W + 1);

    logic          clk;
    logic          rst;
    logic          start;
    logic [3:0]    btn;
    logic [3:0]    vote;
    logic [3:0]    voted;
    logic          session_open;
    logic          done;
    logic [TW-1:0] time_left;

    int n_tests = 0;
    int n_fail  = 0;

    vote_collector #(
        .N_VOTERS       (4),
        .DEBOUNCE_CYCLES(D),
        .WINDOW_CYCLES  (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .btn         (btn),
        .vote        (vote),
        .voted       (voted),
        .session_open(session_open),
        .done        (done),
        .time_left   (time_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference model: a level flips once the last D+1 synced samples all disagree with it.
    bit         m_valid = 0;
    logic [3:0] m_s1, m_s2, m_lvl, m_prev, m_vote, m_voted;
    bit         m_open, m_done;
    int         m_tl;
    logic [3:0] hq[$];

    always @(posedge clk) begin : model
        logic [3:0] press;
        logic [3:0] nl;
        bit         all_diff;
        if (rst) begin
            m_valid = 1;
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_prev = 0;
            m_vote = 0; m_voted = 0; m_open = 0; m_done = 0; m_tl = 0;
            hq.delete();
        end else begin
            press  = m_lvl & ~m_prev;
            m_done = 0;
            if (!m_open) begin
                if (start) begin
                    m_open = 1; m_vote = 0; m_voted = 0; m_tl = W;
                end
            end else begin
`ifdef VOTE_RETRACT_EN
                m_vote = m_vote ^ press;
`else
                m_vote = m_vote | (press & ~m_voted);
`endif
                m_voted = m_voted | press;
                m_tl    = m_tl - 1;
`ifdef VOTE_RETRACT_EN
                if (m_tl == 0) begin
`else
                if (m_tl == 0 || m_voted == 4'hF) begin
`endif
                    m_open = 0; m_done = 1;
                end
            end
            m_prev = m_lvl;
            hq.push_back(m_s2);
            if (hq.size() > D + 1) void'(hq.pop_front());
            nl = m_lvl;
            if (hq.size() == D + 1) begin
                for (int k = 0; k < 4; k++) begin
                    all_diff = 1;
                    foreach (hq[i]) if (hq[i][k] == m_lvl[k]) all_diff = 0;
                    if (all_diff) nl[k] = ~m_lvl[k];
                end
            end
            m_lvl = nl;
            m_s2  = m_s1;
            m_s1  = btn;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("m_vote",  32'(vote),         32'(m_vote));
            check("m_voted", 32'(voted),        32'(m_voted));
            check("m_open",  32'(session_open), 32'(m_open));
            check("m_done",  32'(done),         32'(m_done));
            check("m_tl",    32'(time_left),    32'(m_tl));
        end
    end

    initial begin : stim
        int         hold[4];
        logic [3:0] b;
        bit         seen;
        clk = 0; rst = 1; start = 0; btn = 0;
        tick(); tick();
        check("rst_vote",  32'(vote),         32'(0));
        check("rst_voted", 32'(voted),        32'(0));
        check("rst_open",  32'(session_open), 32'(0));
        check("rst_done",  32'(done),         32'(0));
        check("rst_tl",    32'(time_left),    32'(0));
        rst = 0;
        tick();

        // Open a session, then hold voters 0 and 2.
        start = 1; tick(); start = 0;
        check("open_tl", 32'(time_left), 32'(W));
        check("open_flag", 32'(session_open), 32'(1));
        repeat (4) tick();
        btn = 4'b0101;
        repeat (D + 3) tick();
        check("lat_before", 32'(vote), 32'(0));
        tick();
        check("lat_vote",  32'(vote),  32'(4'b0101));
        check("lat_voted", 32'(voted), 32'(4'b0101));
        check("lat_open",  32'(session_open), 32'(1));

        // Short glitch on voter 1 must not vote.
        btn[1] = 1; repeat (D - 2) tick(); btn[1] = 0;
        repeat (2 * D + 4) tick();
        check("glitch_v1", 32'(vote[1]), 32'(0));

        // Everyone votes -> early close.
        btn = 4'hF;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (done) seen = 1;
        end
        check("all_done_seen", 32'(seen), 32'(1));
        check("all_vote", 32'(vote), 32'(4'hF));
        check("all_open", 32'(session_open), 32'(0));
        check("all_tl_nz", 32'(time_left != 0), 32'(1));
        tick();
        check("all_done_once", 32'(done), 32'(0));
        btn = 0;
        repeat (3 * D + 4) tick();

        // Timeout with a single voter; start during OPEN ignored.
        start = 1; tick(); start = 0;
        btn = 4'b1000; repeat (D + 6) tick(); btn = 0;
        start = 1; tick(); start = 0;
        repeat (W - (D + 7) - 1) tick();
        check("to_done_early", 32'(done), 32'(0));
        check("to_open_early", 32'(session_open), 32'(1));
        tick();
        check("to_done",  32'(done), 32'(1));
        check("to_vote",  32'(vote), 32'(4'b1000));
        check("to_tl",    32'(time_left), 32'(0));
        repeat (3) tick();
        check("to_hold", 32'(vote), 32'(4'b1000));

        // Mid-session reset.
        start = 1; tick(); start = 0;
        btn = 4'b0011; repeat (D + 4) tick();
        check("mid_vote", 32'(vote), 32'(4'b0011));
`ifdef VOTE_RETRACT_EN
        btn = 4'b0010; repeat (D + 4) tick();
        btn = 4'b0011; repeat (D + 4) tick();
        check("retract_vote", 32'(vote), 32'(4'b0010));
`endif
        rst = 1; tick();
        check("mid_rst_vote", 32'(vote), 32'(0));
        check("mid_rst_open", 32'(session_open), 32'(0));
        check("mid_rst_done", 32'(done), 32'(0));
        rst = 0;
        btn = 0;

        // Random traffic against the model.
        for (int k = 0; k < 4; k++) hold[k] = $urandom_range(1, 2 * D + 4);
        for (int c = 0; c < 4000; c++) begin
            b = btn;
            for (int k = 0; k < 4; k++) begin
                if (hold[k] == 0) begin
                    b[k] = ~b[k];
                    hold[k] = $urandom_range(1, 2 * D + 4);
                end else begin
                    hold[k]--;
                end
            end
            btn   = b;
            start = ($urandom_range(0, 29) == 0);
            rst   = ($urandom_range(0, 699) == 0);
            tick();
        end
        rst = 0; start = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
